// File: rtl/step_gen.sv
// Debounced button front-end plus CPU clock-enable generator: halt, manual single step, auto step, run.
// Optional STEP_LIMIT_EN adds step_limit input and done output so stepping self-halts at a step count.
module step_gen #(
    parameter int unsigned N_BTN     = 4,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned AUTO_W    = 8,
    parameter int unsigned STEP_IDX  = 0
) (
    input  logic              CCLK,
    input  logic              BTN2,
    input  logic [N_BTN-1:0]  btn_raw,
    input  logic [1:0]        mode,
    input  logic [AUTO_W-1:0] auto_period,
`ifdef STEP_LIMIT_EN
    input  logic [15:0]       step_limit,
    output logic              done,
`endif
    output logic [N_BTN-1:0]  btn_db,
    output logic [N_BTN-1:0]  btn_rise,
    output logic              step_en,
    output logic [15:0]       step_cnt
);

    localparam int unsigned DB_W = 16;
    localparam int unsigned CNT_W = 16;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_HALT   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_RUN    = 2'b11
    } mode_e;

    logic [N_BTN-1:0]  sync1;
    logic [N_BTN-1:0]  sync2;
    logic [DB_W-1:0]   db_cnt    [N_BTN];
    logic [DB_W-1:0]   db_cnt_nx [N_BTN];
    logic [N_BTN-1:0]  btn_db_nx;
    logic [N_BTN-1:0]  btn_rise_nx;
    logic [AUTO_W-1:0] div;
    logic [AUTO_W-1:0] div_nx;
    logic [1:0]        mode_q;
    logic              mode_chg;
    logic              step_nx;
    logic [CNT_W-1:0]  cnt_nx;
`ifdef STEP_LIMIT_EN
    logic              limit_hit;
`endif

    // Debounce: toggle once the synchronised level has disagreed for DB_CYCLES edges in a row
    always_comb begin
        btn_db_nx   = btn_db;
        btn_rise_nx = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            db_cnt_nx[i] = '0;
            if (sync2[i] != btn_db[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    btn_db_nx[i]   = ~btn_db[i];
                    btn_rise_nx[i] = ~btn_db[i];
                end else begin
                    db_cnt_nx[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Step enable: a mode change restarts the divider and swallows that cycle's step
    always_comb begin
        mode_chg = (mode != mode_q);
        div_nx   = '0;
        step_nx  = 1'b0;
        if (!mode_chg) begin
            case (mode_e'(mode))
                MODE_MANUAL: step_nx = btn_rise[STEP_IDX];
                MODE_AUTO: begin
                    if (div == auto_period) begin
                        step_nx = 1'b1;
                    end else begin
                        div_nx = div + AUTO_W'(1);
                    end
                end
                MODE_RUN:  step_nx = 1'b1;
                default:   step_nx = 1'b0;
            endcase
        end
        cnt_nx = step_cnt + CNT_W'(step_en);
`ifdef STEP_LIMIT_EN
        // Look at the count the next edge will hold so the limit is never overshot
        limit_hit = (step_limit != '0) && (cnt_nx == step_limit);
        if (limit_hit) begin
            step_nx = 1'b0;
        end
`endif
    end

    always_ff @(posedge CCLK) begin
        if (BTN2) begin
            sync1    <= '0;
            sync2    <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt[i] <= '0;
            end
            btn_db   <= '0;
            btn_rise <= '0;
            div      <= '0;
            step_en  <= 1'b0;
            step_cnt <= '0;
            mode_q   <= mode;
`ifdef STEP_LIMIT_EN
            done     <= 1'b0;
`endif
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt[i] <= db_cnt_nx[i];
            end
            btn_db   <= btn_db_nx;
            btn_rise <= btn_rise_nx;
            div      <= div_nx;
            step_en  <= step_nx;
            step_cnt <= cnt_nx;
            mode_q   <= mode;
`ifdef STEP_LIMIT_EN
            done     <= limit_hit;
`endif
        end
    end

endmodule

// File: doc/step_gen.md
STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of debounced button channels.
REQ-002 SHALL have parameter DB_CYCLES, default 16, consecutive stable cycles needed to accept a level change (range 1..65535).
REQ-003 SHALL have parameter AUTO_W, default 8, width of auto-step period input.
REQ-004 SHALL have parameter STEP_IDX, default 0, button channel used for the manual single step.
REQ-005 SHALL have ports: CCLK  in  1  sole clock, all logic on the rising edge.
REQ-006 SHALL have ports: BTN2  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: btn_raw  in  N_BTN  asynchronous raw buttons; mode  in  2  00 halt, 01 manual, 10 auto, 11 run; auto_period  in  AUTO_W  auto-step period minus one.
REQ-008 SHALL have ports: btn_db  out  N_BTN  debounced levels; btn_rise  out  N_BTN  one-cycle pulse on debounced 0->1; step_en  out  1  one-cycle CPU clock-enable; step_cnt  out  16  steps issued.

Function
REQ-009 Each btn_raw bit SHALL pass through a two-flop synchroniser before any other use.
REQ-010 Per channel, a counter SHALL increment every cycle the synchronised value differs from btn_db and clear to 0 on any cycle they match.
REQ-011 btn_db SHALL toggle, and the counter clear, on the edge where the counter would reach DB_CYCLES; a glitch shorter than DB_CYCLES cycles SHALL never change btn_db.
REQ-012 Total latency, raw edge held stable to btn_db change, SHALL be exactly 2+DB_CYCLES cycles.
REQ-013 btn_rise[i] SHALL be high for exactly the one cycle in which btn_db[i] first reads 1; no pulse on falling edges.
REQ-014 mode 00: step_en SHALL be 0.
REQ-015 mode 01: step_en SHALL be high for one cycle, the cycle after btn_rise[STEP_IDX]; holding the button SHALL produce only one step.
REQ-016 mode 10: a divider SHALL count 0..auto_period; step_en SHALL pulse in the cycle after the divider equals auto_period, giving a period of auto_period+1 cycles; auto_period=0 SHALL give step_en every cycle.
REQ-017 mode 11: step_en SHALL be 1 every cycle.
REQ-018 Any change of mode SHALL clear the divider to 0 in that cycle and suppress step_en for that cycle.
REQ-019 auto_period changed mid-count SHALL take effect at the next compare; if the divider already exceeds the new value it SHALL wrap through its maximum to 0 without issuing a step.
REQ-020 step_cnt SHALL increment by 1 in each cycle step_en is 1 and wrap 0xFFFF -> 0x0000.

Reset
REQ-021 BTN2 high at a rising edge SHALL clear synchronisers, debounce counters, btn_db, btn_rise, divider, step_en and step_cnt to 0, overriding all other activity including mid-debounce and mid-period.
REQ-022 After BTN2 falls, a button already held high SHALL produce btn_rise after 2+DB_CYCLES cycles as a fresh press.

Configuration
REQ-023 With STEP_LIMIT_EN defined, the block SHALL add input step_limit (16 bits) and output done (1 bit); when step_limit is non-zero and step_cnt equals step_limit, step_en SHALL be held 0 in all modes and done SHALL be 1 until reset or step_limit changes.
REQ-024 Without STEP_LIMIT_EN, step_limit and done SHALL not exist and stepping SHALL never self-halt.

Verification (DB_CYCLES=4, N_BTN=4, AUTO_W=8)
REQ-025 Reset: BTN2 high for 1 cycle with btn_raw=4'hF -> all outputs 0 on the next cycle; btn_db=4'hF exactly 6 cycles after BTN2 falls.
REQ-026 Debounce: btn_raw[0] high for 3 cycles, then low -> btn_db[0] stays 0; held for 10 cycles -> btn_rise[0] single pulse 6 cycles after the raw edge.
REQ-027 Manual: mode=01, press btn_raw[0] for 20 cycles -> exactly one step_en pulse, one cycle after btn_rise[0]; step_cnt=1.
REQ-028 Auto: mode=10, auto_period=3 for 40 cycles -> step_en every 4th cycle, step_cnt=10; auto_period=0 -> step_en continuous.
REQ-029 Wrap and mode switch: step_cnt at 0xFFFE, mode=11 for 3 cycles -> counts 0xFFFF, 0x0000, 0x0001; switching to 10 suppresses step_en for the switch cycle.
REQ-030 STEP_LIMIT_EN: step_limit=5, mode=11 -> exactly 5 step_en pulses, then done=1 and step_cnt holds 5.
